// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int MAX_DATA_BITS = 9;

    // Clocks per oversample tick; zero means the clock is too slow for the line rate.
    function automatic int calc_div(input int clk_frq, input int baud, input int os);
        return clk_frq / (baud * os);
    endfunction

    // Expected parity bit for a data word (zero-extended to MAX_DATA_BITS).
    function automatic logic parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clk pulse every CLK_FRQ/(BAUD_RATE*OVERSAMPLE) clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FRQ    = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FRQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 1) begin : g_div_chk
            $error("uart_baud_tick: CLK_FRQ too low for BAUD_RATE*OVERSAMPLE");
        end
    endgenerate

    logic [CW-1:0] cnt_reg;
    logic          last;

    assign last = (cnt_reg == CW'(DIV - 1));
    assign tick = last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (last) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote and a valid/ready output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FRQ    = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int M   = OVERSAMPLE / 2;
    localparam int OSW = $clog2(OVERSAMPLE);

    generate
        if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bits_chk
            $error("uart_rx_os: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
            $error("uart_rx_os: STOP_BITS must be 1 or 2");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
            $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    logic [1:0]           sync_reg;
    logic                 rx_s;
    logic                 tick;
    rx_state_t            state_reg;
    logic [OSW-1:0]       os_cnt_reg;
    logic [3:0]           bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic [1:0]           samp_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_reg;
    logic                 ferr_reg;

    logic os_wrap, samp_a, samp_b, decide, maj, last_stop, commit, ferr_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end
    assign rx_s = sync_reg[1];

    uart_baud_tick #(
        .CLK_FRQ    (CLK_FRQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign os_wrap    = (os_cnt_reg == OSW'(OVERSAMPLE - 1));
    assign samp_a     = (os_cnt_reg == OSW'(M - 1));
    assign samp_b     = (os_cnt_reg == OSW'(M));
    assign decide     = (os_cnt_reg == OSW'(M + 1));
    // Third sample is the live rx_s on the decision tick.
    assign maj        = (samp_reg[0] & samp_reg[1]) | (rx_s & (samp_reg[0] | samp_reg[1]));
    assign last_stop  = (stop_cnt_reg == 1'(STOP_BITS - 1));
    assign commit     = tick && (state_reg == STOP) && decide && last_stop;
    assign ferr_final = ferr_reg | ~maj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            samp_reg     <= 2'b00;
            shift_reg    <= '0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
        end else if (tick) begin
            if (state_reg != IDLE) begin
                os_cnt_reg <= os_wrap ? '0 : os_cnt_reg + OSW'(1);
                if (samp_a) samp_reg[0] <= rx_s;
                if (samp_b) samp_reg[1] <= rx_s;
            end
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg  <= START;
                        os_cnt_reg <= '0;
                        perr_reg   <= 1'b0;
                        ferr_reg   <= 1'b0;
                    end
                end
                START: begin
                    if (decide && maj) begin
                        state_reg <= IDLE;
                    end else if (os_wrap) begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                    end
                end
                DATA: begin
                    if (decide) shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                    if (os_wrap) begin
                        if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                            bit_cnt_reg  <= '0;
                            stop_cnt_reg <= 1'b0;
                            state_reg    <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        perr_reg <= maj != parity(MAX_DATA_BITS'(shift_reg), PARITY_ODD != 0);
                    end
                    if (os_wrap) begin
                        state_reg    <= STOP;
                        stop_cnt_reg <= 1'b0;
                    end
                end
                STOP: begin
                    // Leave on the last decision tick so a back-to-back start edge is not missed.
                    if (decide) begin
                        if (!maj) ferr_reg <= 1'b1;
                        if (last_stop) state_reg <= IDLE;
                    end else if (os_wrap) begin
                        stop_cnt_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_reg;
                    parity_err <= perr_reg;
                    frame_err  <= ferr_final;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
